// File: rtl/int_controller.sv
// Four-line edge-triggered interrupt controller: pending latch, enable mask,
// fixed-priority arbitration (irq[0] highest) and a take/service handshake with the CPU.
module int_controller #(
    parameter int unsigned         PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] VEC0     = 10'b1111111011,
    parameter logic [PC_WIDTH-1:0] VEC1     = 10'b1111111110,
    parameter logic [PC_WIDTH-1:0] VEC2     = 10'b1111111101,
    parameter logic [PC_WIDTH-1:0] VEC3     = 10'b1111111100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          irq,
    input  logic                ie_we,
    input  logic [3:0]          ie_wd,
    input  logic                fetch,
    input  logic                iret,
    output logic                int_take,
    output logic [PC_WIDTH-1:0] vector,
    output logic [1:0]          irq_id,
    output logic                int_active,
    output logic [3:0]          pending,
    output logic [3:0]          ie
);

    typedef enum logic [1:0] {
        IDLE,
        TAKE,
        SERVICE
    } state_t;

    state_t              state;
    logic [3:0]          irq_prev;
    logic [3:0]          edges;
    logic [3:0]          eligible;
    logic [3:0]          grant;
    logic [1:0]          winner;
    logic [PC_WIDTH-1:0] win_vec;
    logic                accept;

    always_comb begin
        edges    = irq & ~irq_prev;
        eligible = pending & ie;

        winner = '0;
        priority casez (eligible)
            4'b???1: winner = 2'd0;
            4'b??10: winner = 2'd1;
            4'b?100: winner = 2'd2;
            4'b1000: winner = 2'd3;
            default: winner = '0;
        endcase

        win_vec = VEC0;
        case (winner)
            2'd0:    win_vec = VEC0;
            2'd1:    win_vec = VEC1;
            2'd2:    win_vec = VEC2;
            default: win_vec = VEC3;
        endcase

        accept = (state == IDLE) && fetch && (eligible != '0);
        grant  = accept ? (4'b0001 << winner) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            irq_prev   <= '0;
            pending    <= '0;
            ie         <= '0;
            vector     <= '0;
            irq_id     <= '0;
            int_take   <= 1'b0;
            int_active <= 1'b0;
        end else begin
            irq_prev <= irq;
            // A fresh edge on the line being accepted keeps it pending.
            pending  <= (pending & ~grant) | edges;
            if (ie_we) ie <= ie_wd;

            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= TAKE;
                        int_take   <= 1'b1;
                        int_active <= 1'b1;
                        vector     <= win_vec;
                        irq_id     <= winner;
                    end
                end
                TAKE: begin
                    state    <= SERVICE;
                    int_take <= 1'b0;
                end
                SERVICE: begin
                    if (iret) begin
                        state      <= IDLE;
                        int_active <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    int_take   <= 1'b0;
                    int_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of pending/mask/busy behaviour.
module tb_int_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] irq = '0;
    logic       ie_we = 1'b0;
    logic [3:0] ie_wd = '0;
    logic       fetch = 1'b0;
    logic       iret = 1'b0;
    logic       int_take;
    logic [9:0] vector;
    logic [1:0] irq_id;
    logic       int_active;
    logic [3:0] pending;
    logic [3:0] ie;

    int_controller #(.PC_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .irq(irq), .ie_we(ie_we), .ie_wd(ie_wd),
        .fetch(fetch), .iret(iret), .int_take(int_take), .vector(vector),
        .irq_id(irq_id), .int_active(int_active), .pending(pending), .ie(ie)
    );

    always #5 clk = ~clk;

    logic [9:0] vtab [4] = '{10'b1111111011, 10'b1111111110, 10'b1111111101, 10'b1111111100};

    int total = 0;
    int bad   = 0;

    logic [3:0] m_pend, m_ie, m_prev;
    logic       m_busy, m_take;
    logic [9:0] m_vec;
    logic [1:0] m_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_zero();
        m_pend = '0; m_ie = '0; m_prev = '0;
        m_busy = 1'b0; m_take = 1'b0; m_vec = '0; m_id = '0;
    endtask

    // One clock of the model: a request is a rising edge, the lowest enabled
    // pending index is served, and nothing new is served until iret.
    task automatic model_edge();
        logic [3:0] elig;
        logic [3:0] clr;
        int w;
        if (reset) begin
            model_zero();
        end else begin
            elig = m_pend & m_ie;
            clr  = '0;
            w    = 0;
            if (!m_busy && fetch && elig != 0) begin
                for (int n = 3; n >= 0; n--) if (elig[n]) w = n;
                m_vec  = vtab[w];
                m_id   = w[1:0];
                clr[w] = 1'b1;
                m_busy = 1'b1;
                m_take = 1'b1;
            end else begin
                if (m_busy && !m_take && iret) m_busy = 1'b0;
                m_take = 1'b0;
            end
            m_pend = (m_pend & ~clr) | (irq & ~m_prev);
            m_prev = irq;
            if (ie_we) m_ie = ie_wd;
        end
    endtask

    task automatic compare();
        check("int_take",   int_take,   m_take);
        check("int_active", int_active, m_busy);
        check("vector",     vector,     m_vec);
        check("irq_id",     irq_id,     m_id);
        check("pending",    pending,    m_pend);
        check("ie",         ie,         m_ie);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic drive(input logic [3:0] i, input logic we, input logic [3:0] wd,
                         input logic f, input logic r);
        irq = i; ie_we = we; ie_wd = wd; fetch = f; iret = r;
        step();
    endtask

    // Reset lands between clock edges so its asynchronous effect is visible at once.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_zero();
        compare();
        check("rst_take",   int_take,   1'b0);
        check("rst_active", int_active, 1'b0);
        step();
        step();
        reset = 1'b0;
    endtask

    int ntake;

    initial begin
        model_zero();
        #2;
        do_reset();

        // Single request on irq[2], fetch held.
        drive(4'h0, 1'b1, 4'hF, 1'b1, 1'b0);
        drive(4'h4, 1'b0, 4'h0, 1'b1, 1'b0);
        check("t1_pend", pending, 4'b0100);
        drive(4'h4, 1'b0, 4'h0, 1'b1, 1'b0);
        check("t1_take", int_take, 1'b1);
        check("t1_vec",  vector, 10'b1111111101);
        check("t1_id",   irq_id, 2'd2);
        drive(4'h4, 1'b0, 4'h0, 1'b1, 1'b0);
        check("t1_take_once", int_take, 1'b0);
        check("t1_pend_clr",  pending, 4'b0000);
        repeat (3) drive(4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
        check("t1_active", int_active, 1'b1);
        drive(4'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        check("t1_iret", int_active, 1'b0);

        // Simultaneous irq[3] and irq[1]: priority, then the leftover after iret.
        drive(4'hA, 1'b0, 4'h0, 1'b1, 1'b0);
        drive(4'hA, 1'b0, 4'h0, 1'b1, 1'b0);
        check("t2_vec1", vector, 10'b1111111110);
        check("t2_id1",  irq_id, 2'd1);
        drive(4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
        drive(4'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        drive(4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
        check("t2_take3", int_take, 1'b1);
        check("t2_vec3",  vector, 10'b1111111100);
        check("t2_id3",   irq_id, 2'd3);

        // No nesting: irq[0] arrives while serving id 3.
        drive(4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
        drive(4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
        check("t4_nonest", int_take, 1'b0);
        check("t4_pend",   pending, 4'b0001);
        drive(4'h1, 1'b0, 4'h0, 1'b1, 1'b1);
        drive(4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
        check("t4_vec0", vector, 10'b1111111011);
        drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b1);

        // Masked request waits, then fires once enabled.
        drive(4'h0, 1'b1, 4'h0, 1'b1, 1'b0);
        drive(4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
        repeat (10) drive(4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
        check("t3_masked", pending, 4'b0001);
        drive(4'h0, 1'b1, 4'h1, 1'b1, 1'b0);
        drive(4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
        check("t3_take", int_take, 1'b1);
        check("t3_vec",  vector, 10'b1111111011);
        drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b1);

        // Reset during SERVICE with two more requests pending.
        drive(4'h0, 1'b1, 4'hF, 1'b0, 1'b0);
        drive(4'h8, 1'b0, 4'h0, 1'b0, 1'b0);
        drive(4'h8, 1'b0, 4'h0, 1'b1, 1'b0);
        drive(4'h6, 1'b0, 4'h0, 1'b0, 1'b0);
        drive(4'h6, 1'b0, 4'h0, 1'b1, 1'b0);
        check("t5_pend", pending, 4'b0110);
        irq = 4'h0;
        do_reset();
        check("t5_pend_rst", pending, 4'b0000);
        check("t5_ie_rst",   ie, 4'b0000);
        repeat (4) drive(4'h0, 1'b0, 4'h0, 1'b1, 1'b0);

        // irq[1] high across reset release: one take only.
        irq = 4'h2;
        do_reset();
        ntake = 0;
        drive(4'h2, 1'b1, 4'h2, 1'b1, 1'b0);
        check("t6_pend", pending, 4'b0010);
        for (int c = 0; c < 8; c++) begin
            drive(4'h2, 1'b0, 4'h0, 1'b1, (c == 4) ? 1'b1 : 1'b0);
            if (int_take) ntake++;
        end
        check("t6_ntake", ntake, 1);
        drive(4'h2, 1'b0, 4'h0, 1'b1, 1'b1);
        check("t6_idle_iret", int_active, 1'b0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            drive(irq ^ 4'($urandom & $urandom & $urandom),
                  ($urandom_range(0, 7) == 0), 4'($urandom),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Interrupt controller for the 8-bit CPU.
- Edge-detects four interrupt request lines and latches them as pending. Line 3 is normally driven by the timer `clock_out` pulse.
- Masks pending requests with a software-written enable register and arbitrates by fixed priority.
- At an instruction boundary, issues a one-cycle take strobe and a 10-bit vector, which the CPU uses to push the PC onto the stack and load the vector. It then blocks further interrupts until return-from-interrupt.

Parameters:
- PC_WIDTH, 10, width of the vector and program counter.
- VEC0, 10'b1111111011, vector for irq[0] (highest priority).
- VEC1, 10'b1111111110, vector for irq[1].
- VEC2, 10'b1111111101, vector for irq[2].
- VEC3, 10'b1111111100, vector for irq[3] (lowest priority, timer).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clock clk.
- irq  input  4  request lines, synchronous to clk; rising edge = request.
- ie_we  input  1  enable-mask write strobe.
- ie_wd  input  4  enable-mask write data; bit n enables irq[n].
- fetch  input  1  CPU at instruction boundary, interrupt may be taken this cycle.
- iret  input  1  CPU executing return-from-interrupt (stack pop of PC).
- int_take  output  1  one-cycle strobe: CPU pushes next PC and loads vector.
- vector  output  PC_WIDTH  vector of the accepted interrupt; held until iret.
- irq_id  output  2  index of the accepted interrupt.
- int_active  output  1  high from int_take until iret accepted.
- pending  output  4  pending latch contents.
- ie  output  4  current enable mask.

Behaviour:
- Reset (async): all outputs and internal registers go to 0. This includes pending, ie, state, vector, irq_id and irq_prev.
  - Because irq_prev resets to 0, a line already high when reset releases registers as an edge on the first clock.
- Edge detect: irq_prev <= irq every cycle. edge[n] = irq[n] & ~irq_prev[n].
- Pending: pending[n] is set on edge[n] regardless of ie, and stays set until accepted.
  - Only the accepted bit is cleared.
  - If an edge on line n arrives on the same clock that clears n, set wins and pending[n] stays 1.
- Mask: on ie_we, ie <= ie_wd. The new mask is used by arbitration from the next cycle.
- Eligible = pending & ie.
- Winner = lowest set index of eligible (irq[0] highest), equivalent to the priority encoding used by the vector mux.
- FSM, three states:
  - IDLE: int_active=0, int_take=0.
    - If fetch=1 and eligible!=0, go to TAKE on this edge. On the same edge: vector <= VEC[winner], irq_id <= winner, pending[winner] cleared.
    - Otherwise stay in IDLE.
  - TAKE: lasts exactly one cycle. int_take=1, int_active=1, vector/irq_id valid.
    - Unconditionally go to SERVICE.
    - fetch and iret are ignored in TAKE.
  - SERVICE: int_active=1, int_take=0, vector/irq_id held.
    - On iret=1, go to IDLE.
    - No nesting: eligible requests stay pending and fetch is ignored.
- Latency:
  - Minimum from irq rising edge to int_take is 2 cycles: edge sampled into pending, then fetch with eligible enters TAKE, and int_take asserts in the following cycle.
  - After iret, a remaining eligible request can be taken on the next fetch in IDLE (earliest int_take 2 cycles after the iret edge).
- iret while in IDLE is ignored, with no state change and no error.
- Disabling a line's ie bit while it is pending keeps the bit pending. It fires once re-enabled.
- Reset mid-TAKE/SERVICE returns to IDLE with pending cleared. int_take and int_active drop immediately (asynchronously).
- Outputs int_take, int_active, vector and irq_id are registered or decoded from state only; no combinational path from inputs.

Test Plan:
- Reset, ie_we=1 with ie_wd=4'b1111, pulse irq[2] high for 3 cycles, fetch held at 1 -> pending=4'b0100 after 1 cycle; int_take high for exactly 1 cycle with vector=10'b1111111101 and irq_id=2; pending returns to 0; int_active stays 1 until iret.
- ie=4'b1111, raise irq[3] and irq[1] on the same cycle, fetch=1 -> first take is vector=10'b1111111110 (id 1). Pulse iret -> second take is vector=10'b1111111100 (id 3) without a new irq edge.
- ie=4'b0000, edge on irq[0], fetch=1 for 10 cycles -> no int_take and pending=4'b0001. Write ie=4'b0001 -> int_take with vector=10'b1111111011 within 2 cycles.
- In SERVICE (id 3), edge on irq[0] with fetch=1 -> no int_take while int_active=1; pending=4'b0001. iret -> irq[0] taken next.
- Assert reset while in SERVICE with pending=4'b0110 -> int_active, int_take, pending and ie all 0 immediately; no take after reset release until new edges arrive and ie is rewritten.
- Hold irq[1] high through reset release, with ie=4'b0010 written and fetch=1 -> exactly one take for id 1, no repeat while the line stays high. iret in IDLE -> no change.
